reg_to_obi_bridge: RTL and testbench



---
 rtl/core_v_mini_mcu_pkg.sv | 6 +
 rtl/obi_pkg.sv | 18 +
 rtl/reg_pkg.sv | 19 +
 rtl/reg_to_obi_bridge.sv | 174 +++++++++++++++++
 tb/tb_reg_to_obi_bridge.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-wide integration constants shared by all instances of the bus bridges.
package core_v_mini_mcu_pkg;

  localparam int unsigned REG_TO_OBI_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response types used by the system bus masters and slaves.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/reg_pkg.sv
// Register-bus request/response types shared by every reg_pkg responder and
// initiator in the system.
package reg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/reg_to_obi_bridge.sv
// Register-bus responder that replays each single transaction as one OBI master
// transaction, with a timeout that completes with error and then drains the OBI side.
module reg_to_obi_bridge #(
  parameter type         reg_req_t     = reg_pkg::reg_req_t,
  parameter type         reg_rsp_t     = reg_pkg::reg_rsp_t,
  parameter type         obi_req_t     = obi_pkg::obi_req_t,
  parameter type         obi_resp_t    = obi_pkg::obi_resp_t,
  parameter int unsigned TimeoutCycles = core_v_mini_mcu_pkg::REG_TO_OBI_DEFAULT_TIMEOUT
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  reg_req_t  reg_req_i,
  output reg_rsp_t  reg_rsp_o,
  output obi_req_t  obi_req_o,
  input  obi_resp_t obi_resp_i
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    DONE,
    FLUSH
  } state_e;

  localparam bit          TimeoutEn    = (TimeoutCycles != 32'd0);
  localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic [15:0] cnt_q, cnt_d;
  logic        gnt_seen_q, gnt_seen_d;
  logic        pending_flush_q, pending_flush_d;

  logic        req_active;
  logic        expired;
  logic        flush_owes_gnt;

  // After a timeout the OBI request must stay up until it is granted, even
  // though the register side has already been answered.
  assign flush_owes_gnt = pending_flush_q && !gnt_seen_q;
  assign req_active     = (state_q == REQ) ||
                          (((state_q == DONE) || (state_q == FLUSH)) && flush_owes_gnt);
  // Compare with >= so a gnt that wins the expiry cycle still leaves RESP bounded.
  assign expired        = TimeoutEn && (cnt_q >= TimeoutLimit);

  always_comb begin
    // NOTE: every variable gets its default first so no path can infer a latch.
    state_d         = state_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    be_d            = be_q;
    rdata_d         = rdata_q;
    error_d         = error_q;
    cnt_d           = cnt_q;
    gnt_seen_d      = gnt_seen_q;
    pending_flush_d = pending_flush_q;

    if (req_active && obi_resp_i.gnt) begin
      gnt_seen_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (reg_req_i.valid) begin
          addr_d          = reg_req_i.addr;
          we_d            = reg_req_i.write;
          wdata_d         = reg_req_i.wdata;
          be_d            = reg_req_i.wstrb;
          cnt_d           = '0;
          gnt_seen_d      = 1'b0;
          pending_flush_d = 1'b0;
          state_d         = REQ;
        end
      end

      REQ: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
        if (obi_resp_i.gnt) begin
          state_d = RESP;
        end else if (expired) begin
          rdata_d         = '0;
          error_d         = 1'b1;
          pending_flush_d = 1'b1;
          state_d         = DONE;
        end
      end

      RESP: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
        if (obi_resp_i.rvalid) begin
          rdata_d = we_q ? 32'h0 : obi_resp_i.rdata;
          error_d = 1'b0;
          state_d = DONE;
        end else if (expired) begin
          rdata_d         = '0;
          error_d         = 1'b1;
          pending_flush_d = 1'b1;
          state_d         = DONE;
        end
      end

      DONE: begin
        if (!pending_flush_q) begin
          state_d = IDLE;
        end else if (gnt_seen_q && obi_resp_i.rvalid) begin
          // The late response landed while we were answering; nothing left to drain.
          pending_flush_d = 1'b0;
          state_d         = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        if (gnt_seen_q && obi_resp_i.rvalid) begin
          pending_flush_d = 1'b0;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      be_q            <= '0;
      rdata_q         <= '0;
      error_q         <= 1'b0;
      cnt_q           <= '0;
      gnt_seen_q      <= 1'b0;
      pending_flush_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      be_q            <= be_d;
      rdata_q         <= rdata_d;
      error_q         <= error_d;
      cnt_q           <= cnt_d;
      gnt_seen_q      <= gnt_seen_d;
      pending_flush_q <= pending_flush_d;
    end
  end

  // Outputs decode flops only; nothing from reg_req_i or obi_resp_i reaches them.
  always_comb begin
    obi_req_o       = '0;
    obi_req_o.req   = req_active;
    obi_req_o.we    = we_q;
    obi_req_o.be    = be_q;
    obi_req_o.addr  = addr_q;
    obi_req_o.wdata = wdata_q;

    reg_rsp_o       = '0;
    reg_rsp_o.ready = (state_q == DONE);
    reg_rsp_o.rdata = rdata_q;
    reg_rsp_o.error = error_q;
  end

endmodule

// File: tb/tb_reg_to_obi_bridge.sv
// Self-checking bench: a queue-driven OBI slave plus a cycle-arithmetic reference
// model of completion time, data and error for each register transaction.
module tb_reg_to_obi_bridge;
  import reg_pkg::*;
  import obi_pkg::*;

  localparam int T = 8;

  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  reg_req_t  reg_req = '0;
  reg_rsp_t  reg_rsp;
  obi_req_t  obi_req;
  obi_resp_t obi_resp = '0;

  int cyc        = 0;
  int n_checks   = 0;
  int n_fail     = 0;
  int req_cycles = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_to_obi_bridge #(
    .TimeoutCycles(T)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .reg_req_i (reg_req),
    .reg_rsp_o (reg_rsp),
    .obi_req_o (obi_req),
    .obi_resp_i(obi_resp)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // OBI slave: each transaction pops {gnt wait, rvalid delay after gnt, rdata}.
  typedef struct {
    int          g;
    int          r;
    logic [31:0] rdata;
  } scfg_t;

  scfg_t    cfg_q[$];
  obi_req_t obs_q[$];
  bit       busy    = 1'b0;
  int       held    = 0;
  int       rv_left = 0;
  scfg_t    cur;
  obi_req_t first;

  always @(negedge clk) begin
    obi_resp.gnt    = 1'b0;
    obi_resp.rvalid = 1'b0;
    obi_resp.rdata  = '0;
    if (!rst_n) begin
      busy    = 1'b0;
      rv_left = 0;
    end else begin
      if (rv_left > 0) begin
        rv_left--;
        if (rv_left == 0) begin
          obi_resp.rvalid = 1'b1;
          obi_resp.rdata  = cur.rdata;
        end
      end
      if (obi_req.req) begin
        req_cycles++;
        if (!busy) begin
          busy  = 1'b1;
          held  = 0;
          first = obi_req;
          check("cfg_avail", cfg_q.size() > 0, 1'b1);
          if (cfg_q.size() > 0) cur = cfg_q.pop_front();
          else cur = '{0, 1, 32'h0};
        end else begin
          held++;
          check("req_stable", obi_req, first);
        end
        if (held == cur.g) begin
          obi_resp.gnt = 1'b1;
          busy         = 1'b0;
          rv_left      = cur.r;
          obs_q.push_back(obi_req);
        end
      end
    end
  end

  // Timeline relative to the valid cycle: gnt at 1+g, rvalid r cycles later. The
  // first cycle from T+1 on that carries neither event is the expiry cycle; if it
  // precedes rvalid the register side sees an error one cycle later.
  function automatic void ref_model(input int g, input int r, input logic we,
                                    input logic [31:0] rd, output int lat,
                                    output logic err, output logic [31:0] rdata);
    int gnt_at = 1 + g;
    int rv_at  = gnt_at + r;
    int c      = T + 1;
    while (c == gnt_at || c == rv_at) c++;
    if (c < rv_at) begin
      lat = c + 1; err = 1'b1; rdata = 32'h0;
    end else begin
      lat = rv_at + 1; err = 1'b0; rdata = we ? 32'h0 : rd;
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
    reg_req.addr  = addr;
    reg_req.write = we;
    reg_req.wdata = wdata;
    reg_req.wstrb = wstrb;
    reg_req.valid = 1'b1;
  endtask

  task automatic wait_ready(output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (reg_rsp.ready) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_quiet(input string tag);
    int  budget = 200;
    bit  stray  = 1'b0;
    while (budget > 0 && !(cfg_q.size() == 0 && !busy && rv_left == 0)) begin
      if (reg_rsp.ready) stray = 1'b1;
      tick();
      budget--;
    end
    check({tag, "_quiet"}, budget > 0, 1'b1);
    tick();
    if (reg_rsp.ready) stray = 1'b1;
    check({tag, "_no_ready_flush"}, stray, 1'b0);
  endtask

  task automatic check_obs(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    obi_req_t o;
    check({tag, "_obs_cnt"}, obs_q.size() > 0, 1'b1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check({tag, "_addr"}, o.addr, addr);
      check({tag, "_we"}, o.we, we);
      check({tag, "_be"}, o.be, wstrb);
      check({tag, "_wdata"}, o.wdata, wdata);
    end
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int g, input int r,
                         input logic [31:0] rd, input string tag);
    int          t0, at, rc0, exp_lat;
    bit          ok;
    logic        exp_err;
    logic [31:0] exp_rd;
    ref_model(g, r, we, rd, exp_lat, exp_err, exp_rd);
    cfg_q.push_back('{g, r, rd});
    rc0 = req_cycles;
    drive_req(we, addr, wdata, wstrb);
    t0 = cyc;
    wait_ready(at, ok);
    reg_req.valid = 1'b0;
    check({tag, "_ready"}, ok, 1'b1);
    check({tag, "_lat"}, at - t0, exp_lat);
    check({tag, "_rdata"}, reg_rsp.rdata, exp_rd);
    check({tag, "_err"}, reg_rsp.error, exp_err);
    tick();
    check({tag, "_pulse"}, reg_rsp.ready, 1'b0);
    wait_quiet(tag);
    check({tag, "_req_cycles"}, req_cycles - rc0, g + 1);
    check_obs(tag, we, addr, wdata, wstrb);
  endtask

  initial begin
    int          t0, at;
    bit          ok;
    logic        we;
    logic [31:0] a, d, rd;
    logic [3:0]  s;

    tick();
    tick();
    check("rst_obi", obi_req, '0);
    check("rst_rsp", reg_rsp, '0);
    rst_n = 1'b1;
    tick();
    check("idle_req", obi_req.req, 1'b0);
    check("idle_ready", reg_rsp.ready, 1'b0);

    run_txn(1'b0, 32'h2000_0010, 32'h0BAD_0BAD, 4'hF, 0, 1, 32'hDEAD_BEEF, "rd_zero_wait");
    run_txn(1'b1, 32'h2000_0020, 32'h1234_5678, 4'h3, 4, 1, 32'h5555_AAAA, "wr_gnt_stall");
    run_txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 12, 2, 32'h7777_8888, "gnt_timeout");
    run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, T, 1, 32'h1357_9BDF, "gnt_collide");
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, T, 32'h2468_ACE0, "rv_collide");
    run_txn(1'b1, 32'h3000_000C, 32'hFFFF_0000, 4'hC, T, 5, 32'h0, "gnt_collide_late_rv");

    // rvalid timeout with a second read held during the flush.
    cfg_q.push_back('{0, 19, 32'h1111_2222});
    cfg_q.push_back('{0, 1, 32'hCAFE_0001});
    drive_req(1'b0, 32'h2000_0040, 32'h0, 4'hF);
    t0 = cyc;
    wait_ready(at, ok);
    reg_req.valid = 1'b0;
    check("rv_to_lat", at - t0, T + 2);
    check("rv_to_err", reg_rsp.error, 1'b1);
    check("rv_to_rdata", reg_rsp.rdata, 32'h0);
    while (cyc < t0 + 12) tick();
    drive_req(1'b0, 32'h2000_0044, 32'h0, 4'hF);
    wait_ready(at, ok);
    reg_req.valid = 1'b0;
    check("rv_to_second_lat", at - t0, 24);
    check("rv_to_second_rdata", reg_rsp.rdata, 32'hCAFE_0001);
    check("rv_to_second_err", reg_rsp.error, 1'b0);
    tick();
    wait_quiet("rv_to");
    check_obs("rv_to_first", 1'b0, 32'h2000_0040, 32'h0, 4'hF);
    check_obs("rv_to_second", 1'b0, 32'h2000_0044, 32'h0, 4'hF);

    // Asynchronous reset while waiting for rvalid.
    cfg_q.push_back('{0, 30, 32'h0});
    drive_req(1'b1, 32'h1234_0000, 32'h9999_9999, 4'hF);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_obi", obi_req, '0);
    check("midrst_rsp", reg_rsp, '0);
    reg_req.valid = 1'b0;
    cfg_q.delete();
    obs_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1, 32'h600D_F00D, "post_rst");

    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      rd = $urandom;
      s  = 4'($urandom_range(0, 15));
      run_txn(we, a, d, s, $urandom_range(0, 11), $urandom_range(1, 12), rd, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
